// File: rtl/stg_arb_pkg.sv
// Shared types and defaults for the two-channel STG arbiter.
// Optional handshake timeout is enabled with `define STG_ARB_TIMEOUT_EN.
package stg_arb_pkg;

  localparam int unsigned STG_ARB_DATA_W  = 4;
  localparam int unsigned STG_ARB_TIMEOUT = 15;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEND    = 2'd1,
    RELEASE = 2'd2,
    ACK     = 2'd3
  } stg_state_t;

endpackage

// File: rtl/stg_sync2.sv
// One-bit two-flop synchronizer with synchronous active-high reset.
module stg_sync2 (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/stg_arbiter.sv
// Two-requester round-robin arbiter bridging 4-phase handshakes onto one downstream STG stage.
// Define STG_ARB_TIMEOUT_EN to add the per-phase handshake timeout and sticky err flag.
module stg_arbiter
  import stg_arb_pkg::*;
#(
  parameter int unsigned DATA_W  = STG_ARB_DATA_W,
  parameter int unsigned TIMEOUT = STG_ARB_TIMEOUT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        rin,
  output logic [1:0]        ain,
  input  logic [DATA_W-1:0] data_in0,
  input  logic [DATA_W-1:0] data_in1,
  output logic              rout,
  input  logic              aout,
  output logic [DATA_W-1:0] data_out,
  output logic              err
);

  if (TIMEOUT == 0) begin : g_timeout_check
    $error("stg_arbiter: TIMEOUT must be at least 1");
  end

  logic [1:0] rin_s;
  logic       aout_s;

  stg_sync2 u_sync_rin0 (.clk(clk), .reset(reset), .d(rin[0]), .q(rin_s[0]));
  stg_sync2 u_sync_rin1 (.clk(clk), .reset(reset), .d(rin[1]), .q(rin_s[1]));
  stg_sync2 u_sync_aout (.clk(clk), .reset(reset), .d(aout),   .q(aout_s));

  stg_state_t        state_q, state_d;
  logic              gnt_q, gnt_d;
  logic              last_q, last_d;
  logic [DATA_W-1:0] data_d;
  logic              rout_d;
  logic [1:0]        ain_d;

`ifdef STG_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      gnt_q    <= 1'b0;
      last_q   <= 1'b1;
      data_out <= '0;
      rout     <= 1'b0;
      ain      <= '0;
`ifdef STG_ARB_TIMEOUT_EN
      cnt_q    <= '0;
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      last_q   <= last_d;
      data_out <= data_d;
      rout     <= rout_d;
      ain      <= ain_d;
`ifdef STG_ARB_TIMEOUT_EN
      cnt_q    <= cnt_d;
      err_q    <= err_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    data_d  = data_out;
`ifdef STG_ARB_TIMEOUT_EN
    cnt_d   = cnt_q;
    err_d   = err_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (|rin_s) begin
          // On a tie the channel that did not win last time is chosen.
          gnt_d   = (rin_s == 2'b11) ? ~last_q : rin_s[1];
          data_d  = gnt_d ? data_in1 : data_in0;
          state_d = SEND;
`ifdef STG_ARB_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end

      SEND: begin
        if (aout_s) begin
          state_d = RELEASE;
`ifdef STG_ARB_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
`ifdef STG_ARB_TIMEOUT_EN
        else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_d == CNT_W'(TIMEOUT)) begin
            err_d   = 1'b1;
            state_d = ACK;
          end
        end
`endif
      end

      RELEASE: begin
        if (!aout_s) begin
          state_d = ACK;
        end
`ifdef STG_ARB_TIMEOUT_EN
        else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_d == CNT_W'(TIMEOUT)) begin
            err_d   = 1'b1;
            state_d = ACK;
          end
        end
`endif
      end

      ACK: begin
        // A request withdrawn earlier simply lets this state exit at once.
        if (!rin_s[gnt_q]) begin
          last_d  = gnt_q;
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    rout_d = (state_d == SEND);
    ain_d  = (state_d == ACK) ? (gnt_d ? 2'b10 : 2'b01) : 2'b00;
  end

endmodule

// File: tb/tb_stg_arbiter.sv
// Scoreboard bench for stg_arbiter: random 4-phase requesters, delayed responder, queue-based checks.
// Build with +define+STG_ARB_TIMEOUT_EN to exercise the timeout path instead of the stall path.
module tb_stg_arbiter;

  localparam int DW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          rin0, rin1;
  logic [1:0]    rin;
  logic [1:0]    ain;
  logic [DW-1:0] data_in0, data_in1, data_out;
  logic          rout, aout, err;

  assign rin = {rin1, rin0};

  always #5 clk = ~clk;

  stg_arbiter #(.DATA_W(DW), .TIMEOUT(15)) dut (
    .clk(clk), .reset(reset), .rin(rin), .ain(ain),
    .data_in0(data_in0), .data_in1(data_in1),
    .rout(rout), .aout(aout), .data_out(data_out), .err(err)
  );

  typedef struct {
    bit            ch;
    logic [DW-1:0] data;
  } txn_t;

  txn_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   model_last = 1'b1;
  bit   resp_en = 1'b0;
  bit   mon_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input bit ch, input logic [DW-1:0] d);
    txn_t t;
    t.ch = ch;
    t.data = d;
    exp_q.push_back(t);
  endtask

  // Downstream responder: follows rout with a 3-cycle delay on both edges.
  initial begin
    int dly;
    aout = 1'b0;
    dly = 0;
    forever begin
      @(negedge clk);
      if (!resp_en) begin
        aout = 1'b0;
        dly = 0;
      end else if (rout !== aout) begin
        dly++;
        if (dly >= 3) begin
          aout = rout;
          dly = 0;
        end
      end else begin
        dly = 0;
      end
    end
  end

  // Monitor: pops the scoreboard whenever an ack rises.
  logic          prev_rout = 1'b0;
  logic [1:0]    prev_ain = 2'b00;
  logic [DW-1:0] prev_data = '0;
  logic [DW-1:0] cap_data = '0;

  always @(negedge clk) begin
    txn_t e;
    if (mon_en) begin
      check("ain_not_both", 32'(ain == 2'b11), 32'd0);
      if (!(rout && !prev_rout))
        check("data_out_stable", 32'(data_out), 32'(prev_data));
      if (rout && !prev_rout)
        cap_data = data_out;
      if (ain != 2'b00 && prev_ain == 2'b00) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_grant: got ain=%b expected no grant", ain);
        end else begin
          e = exp_q.pop_front();
          check("grant_channel", 32'(ain), e.ch ? 32'd2 : 32'd1);
          check("grant_data", 32'(cap_data), 32'(e.data));
        end
      end
    end
    prev_rout = rout;
    prev_ain  = ain;
    prev_data = data_out;
  end

  task automatic wait_ain(input bit ch, input bit val);
    int n = 0;
    while (ain[ch] !== val && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (ain[ch] !== val) begin
      checks++;
      errors++;
      $display("FAIL wait_ain%0d: got %b expected %b", ch, ain[ch], val);
    end
  endtask

  task automatic wait_rout(input bit val);
    int n = 0;
    while (rout !== val && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (rout !== val) begin
      checks++;
      errors++;
      $display("FAIL wait_rout: got %b expected %b", rout, val);
    end
  endtask

  task automatic requester(input bit ch, input int n, input logic [DW-1:0] d0, input logic [DW-1:0] d1);
    for (int r = 0; r < n; r++) begin
      @(negedge clk);
      if (ch) begin
        data_in1 = (r == 0) ? d0 : d1;
        rin1 = 1'b1;
      end else begin
        data_in0 = (r == 0) ? d0 : d1;
        rin0 = 1'b1;
      end
      wait_ain(ch, 1'b1);
      @(negedge clk);
      if (ch) rin1 = 1'b0;
      else    rin0 = 1'b0;
      wait_ain(ch, 1'b0);
    end
  endtask

  // Reference model: pending requesters are served round-robin; a tie goes to the
  // channel not served last, and a re-request from the winner queues behind the other.
  task automatic run_round(input bit use0, input bit use1, input bit rep,
                           input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                           input logic [DW-1:0] d_rep);
    bit first;
    int n0, n1;
    n0 = 1;
    n1 = 1;
    if (use0 && use1) begin
      first = ~model_last;
      push_exp(first, first ? d1 : d0);
      push_exp(~first, first ? d0 : d1);
      if (rep) begin
        push_exp(first, d_rep);
        model_last = first;
        if (first) n1 = 2;
        else       n0 = 2;
      end else begin
        model_last = ~first;
      end
    end else begin
      push_exp(use1, use1 ? d1 : d0);
      model_last = use1;
    end
    fork
      begin if (use0) requester(1'b0, n0, d0, d_rep); end
      begin if (use1) requester(1'b1, n1, d1, d_rep); end
    join
    repeat (6) @(negedge clk);
  endtask

  task automatic random_round();
    bit u0, u1, rp;
    do begin
      u0 = 1'($urandom_range(0, 1));
      u1 = 1'($urandom_range(0, 1));
    end while (!u0 && !u1);
    rp = 1'($urandom_range(0, 1));
    run_round(u0, u1, rp, DW'($urandom), DW'($urandom), DW'($urandom));
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    rin0 = 1'b0;
    rin1 = 1'b0;
    data_in0 = '0;
    data_in1 = '0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset_rout", 32'(rout), 32'd0);
    check("reset_ain", 32'(ain), 32'd0);
    check("reset_data_out", 32'(data_out), 32'd0);
    check("reset_err", 32'(err), 32'd0);
    resp_en = 1'b1;
    mon_en = 1'b1;

    run_round(1'b1, 1'b1, 1'b0, 4'd1, 4'd2, 4'd0);
    run_round(1'b1, 1'b0, 1'b0, 4'd1, 4'd0, 4'd0);
    run_round(1'b1, 1'b1, 1'b1, 4'd5, 4'd9, 4'hc);

    for (int i = 0; i < 20; i++) random_round();

`ifdef STG_ARB_TIMEOUT_EN
    resp_en = 1'b0;
    push_exp(1'b1, 4'd7);
    model_last = 1'b1;
    fork
      requester(1'b1, 1, 4'd7, 4'd7);
      begin
        int n;
        wait_rout(1'b1);
        n = 0;
        while (err !== 1'b1 && n < 30) begin
          @(negedge clk);
          n++;
        end
        check("timeout_latency_ok", 32'(n <= 15), 32'd1);
        check("timeout_err", 32'(err), 32'd1);
        check("timeout_rout", 32'(rout), 32'd0);
        check("timeout_ain", 32'(ain), 32'd2);
      end
    join
    resp_en = 1'b1;
    repeat (6) @(negedge clk);
    mon_en = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("err_cleared_by_reset", 32'(err), 32'd0);
    model_last = 1'b1;
    @(negedge clk);
    mon_en = 1'b1;
`else
    resp_en = 1'b0;
    push_exp(1'b1, 4'd7);
    model_last = 1'b1;
    fork
      requester(1'b1, 1, 4'd7, 4'd7);
      begin
        wait_rout(1'b1);
        repeat (40) @(negedge clk);
        check("stall_rout_held", 32'(rout), 32'd1);
        check("stall_err", 32'(err), 32'd0);
        check("stall_ain", 32'(ain), 32'd0);
        resp_en = 1'b1;
      end
    join
    repeat (6) @(negedge clk);
`endif

    resp_en = 1'b0;
    @(negedge clk);
    data_in0 = 4'd3;
    rin0 = 1'b1;
    wait_rout(1'b1);
    mon_en = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    check("midreset_rout", 32'(rout), 32'd0);
    check("midreset_ain", 32'(ain), 32'd0);
    check("midreset_data_out", 32'(data_out), 32'd0);
    reset = 1'b0;
    rin0 = 1'b0;
    model_last = 1'b1;
    resp_en = 1'b1;
    repeat (4) @(negedge clk);
    check("midreset_no_ack", 32'(ain), 32'd0);
    mon_en = 1'b1;
    run_round(1'b0, 1'b1, 1'b0, 4'd0, 4'ha, 4'd0);

    for (int i = 0; i < 8; i++) random_round();

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
